// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator: first-order sigma-delta bitstream decoder.
// Counts zeros over windows of 2^WIDTH enabled samples.
module sd_adc_decimator #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             sat
);

    localparam logic [WIDTH-1:0] SCNT_LAST = {WIDTH{1'b1}};

    logic             s_bit;
    logic             zbit;
    logic [WIDTH-1:0] scnt;
    logic [WIDTH:0]   zacc;
    logic [WIDTH:0]   z;
    logic             win_end;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_bit = bit_in;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic sync_q;
            // single capture flop, shifts every clk regardless of ena
            always_ff @(posedge clk) begin
                if (!rst_n) sync_q <= 1'b0;
                else        sync_q <= bit_in;
            end
            assign s_bit = sync_q;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] sync_q;
            // shift chain, shifts every clk regardless of ena
            always_ff @(posedge clk) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= {sync_q[SYNC_STAGES-2:0], bit_in};
            end
            assign s_bit = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign zbit    = ~s_bit;
    assign z       = zacc + {{WIDTH{1'b0}}, zbit};
    assign win_end = ena && (scnt == SCNT_LAST);

    // window counter, zero accumulator and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scnt  <= '0;
            zacc  <= '0;
            data  <= '0;
            valid <= 1'b0;
            sat   <= 1'b0;
        end else if (clr) begin
            scnt  <= '0;
            zacc  <= '0;
            valid <= 1'b0;
        end else if (win_end) begin
            data  <= z[WIDTH] ? SCNT_LAST : z[WIDTH-1:0];
            sat   <= z[WIDTH];
            valid <= 1'b1;
            scnt  <= '0;
            zacc  <= '0;
        end else begin
            valid <= 1'b0;
            if (ena) begin
                scnt <= scnt + 1'b1;
                zacc <= z;
            end
        end
    end

endmodule

// File: tb/tb_sd_adc_decimator.sv
// tb_sd_adc_decimator: randomized and directed checks against
// a window-counting model, for sync depths 0, 2 and 3.
module tb_sd_adc_decimator;

    localparam int M_CONST = 0;
    localparam int M_DAC   = 1;
    localparam int M_RAND  = 2;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       clr;
    logic       bit_in;
    logic [7:0] dq [3];
    logic       vq [3];
    logic       sq [3];

    int total;
    int bad;

    int       mode;
    bit       cbit;
    int       strobe;
    int       ph;
    int       dens;
    bit       clr_req;
    bit       rst_req;
    logic [7:0] dac_d;
    logic [7:0] dac_acc;
    logic       dac_bit;

    logic [7:0] s_d [3];
    logic       s_v [3];
    logic       s_s [3];

    bit         armed;
    int         m_cnt [3];
    int         m_z   [3];
    logic [7:0] m_d   [3];
    logic       m_v   [3];
    logic       m_s   [3];
    logic [3:0] m_h   [3];

    sd_adc_decimator #(.WIDTH(8), .SYNC_STAGES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .bit_in(bit_in), .data(dq[0]), .valid(vq[0]), .sat(sq[0])
    );

    sd_adc_decimator #(.WIDTH(8), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .bit_in(bit_in), .data(dq[1]), .valid(vq[1]), .sat(sq[1])
    );

    sd_adc_decimator #(.WIDTH(8), .SYNC_STAGES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .bit_in(bit_in), .data(dq[2]), .valid(vq[2]), .sat(sq[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int sdep(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    // Reference: s_bit is bit_in seen sdep(k) clocks ago (zeros
    // while in reset); count zeros over each 256 enabled samples.
    initial begin
        armed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_z[k] = 0; m_d[k] = '0;
            m_v[k] = 1'b0; m_s[k] = 1'b0; m_h[k] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                logic sb;
                sb = (sdep(k) == 0) ? bit_in : m_h[k][sdep(k)-1];
                if (!rst_n) begin
                    armed    = 1'b1;
                    m_cnt[k] = 0;
                    m_z[k]   = 0;
                    m_d[k]   = '0;
                    m_v[k]   = 1'b0;
                    m_s[k]   = 1'b0;
                    m_h[k]   = '0;
                end else begin
                    m_v[k] = 1'b0;
                    if (clr) begin
                        m_cnt[k] = 0;
                        m_z[k]   = 0;
                    end else if (ena) begin
                        m_z[k]   = m_z[k] + (sb ? 0 : 1);
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == 256) begin
                            m_d[k]   = (m_z[k] > 255) ? 8'd255 : 8'(m_z[k]);
                            m_s[k]   = (m_z[k] == 256);
                            m_v[k]   = 1'b1;
                            m_cnt[k] = 0;
                            m_z[k]   = 0;
                        end
                    end
                    m_h[k] = {m_h[k][2:0], bit_in};
                end
            end
        end
    end

    // every-cycle comparison of all three instances with the model
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if ({dq[k], vq[k], sq[k]} !== {m_d[k], m_v[k], m_s[k]}) begin
                        bad++;
                        $display("FAIL model_s%0d t=%0t got d=%h v=%b s=%b want d=%h v=%b s=%b",
                                 sdep(k), $time, dq[k], vq[k], sq[k],
                                 m_d[k], m_v[k], m_s[k]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // sample outputs of the last edge, then drive the next sample
    task automatic tick();
        logic [8:0] sum;
        logic       e;
        logic       b;
        logic       c;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            s_d[k] = dq[k];
            s_v[k] = vq[k];
            s_s[k] = sq[k];
        end
        if (strobe <= 1) begin
            e = 1'b1;
        end else begin
            e  = (ph == 0);
            ph = (ph + 1) % strobe;
        end
        c = clr_req;
        b = cbit;
        if (mode == M_DAC) begin
            if (e) begin
                sum     = {1'b0, dac_acc} + {1'b0, dac_d};
                dac_acc = sum[7:0];
                dac_bit = ~sum[8];
            end
            b = dac_bit;
        end else if (mode == M_RAND) begin
            e = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 255) >= dens);
            c = clr_req | ($urandom_range(0, 199) == 0);
        end
        ena    = e;
        bit_in = b;
        clr    = c;
        rst_n  = rst_req;
    endtask

    task automatic wait_valid(input int maxc, output int w);
        bit found;
        w     = 0;
        found = 1'b0;
        while (w < maxc && !found) begin
            tick();
            w++;
            if (s_v[1]) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL valid_timeout waited=%0d required<=%0d", w, maxc);
        end
    endtask

    initial begin
        int w;
        logic [7:0] rt [5];
        rt[0] = 8'h5A; rt[1] = 8'h00; rt[2] = 8'h01;
        rt[3] = 8'h80; rt[4] = 8'hFF;
        total = 0; bad = 0;
        ena = 1'b0; clr = 1'b0; bit_in = 1'b1; rst_n = 1'b0;
        mode = M_CONST; cbit = 1'b1; strobe = 1; ph = 0; dens = 128;
        clr_req = 1'b0; rst_req = 1'b0;
        dac_d = 8'h00; dac_acc = 8'h00; dac_bit = 1'b1;

        repeat (3) tick();
        chk("rst_data", int'(s_d[1]), 0);
        chk("rst_valid", int'(s_v[1]), 0);
        chk("rst_sat", int'(s_s[1]), 0);
        rst_req = 1'b1;

        wait_valid(300, w);
        wait_valid(300, w);
        chk("one_period", w, 256);
        chk("one_data", int'(s_d[1]), 0);
        chk("one_sat", int'(s_s[1]), 0);

        cbit = 1'b0;
        wait_valid(300, w);
        wait_valid(300, w);
        chk("zero_data", int'(s_d[1]), 255);
        chk("zero_sat", int'(s_s[1]), 1);

        repeat (98) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("clr_hold", int'(s_d[1]), 255);
        wait_valid(300, w);
        chk("clr_gap", w, 256);
        chk("clr_data", int'(s_d[1]), 255);
        chk("clr_sat", int'(s_s[1]), 1);

        cbit = 1'b1;
        repeat (48) tick();
        rst_req = 1'b0;
        tick();
        tick();
        rst_req = 1'b1;
        tick();
        chk("mid_rst_data", int'(s_d[1]), 0);
        chk("mid_rst_valid", int'(s_v[1]), 0);
        chk("mid_rst_sat", int'(s_s[1]), 0);
        wait_valid(300, w);
        chk("mid_rst_gap", w, 256);
        chk("mid_rst_s0", int'(s_d[0]), 0);
        chk("mid_rst_s2", int'(s_d[1]), 2);
        chk("mid_rst_s3", int'(s_d[2]), 3);

        repeat (254) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("clr_end_valid", int'(s_v[1]), 0);
        chk("clr_end_hold", int'(s_d[1]), 2);
        wait_valid(300, w);
        chk("clr_end_gap", w, 256);
        chk("clr_end_data", int'(s_d[1]), 0);

        repeat (254) tick();
        cbit = 1'b0;
        tick();
        cbit = 1'b1;
        wait_valid(300, w);
        chk("lat_w0_s0", int'(s_d[0]), 1);
        chk("lat_w0_s2", int'(s_d[1]), 0);
        chk("lat_w0_s3", int'(s_d[2]), 0);
        wait_valid(300, w);
        chk("lat_w1_s0", int'(s_d[0]), 0);
        chk("lat_w1_s2", int'(s_d[1]), 1);
        chk("lat_w1_s3", int'(s_d[2]), 1);

        mode = M_DAC;
        for (int i = 0; i < 5; i++) begin
            dac_d = rt[i];
            wait_valid(300, w);
            wait_valid(300, w);
            for (int j = 0; j < 3; j++) begin
                wait_valid(300, w);
                chk("rt_period", w, 256);
                chk("rt_data", int'(s_d[1]), int'(rt[i]));
                chk("rt_sat", int'(s_s[1]), 0);
            end
        end

        dac_d  = 8'h33;
        strobe = 3;
        ph     = 0;
        wait_valid(900, w);
        wait_valid(900, w);
        for (int j = 0; j < 2; j++) begin
            wait_valid(900, w);
            chk("strobe_period", w, 768);
            chk("strobe_data", int'(s_d[1]), 8'h33);
        end

        strobe = 1;
        mode   = M_RAND;
        for (int blk = 0; blk < 6; blk++) begin
            dens = (blk == 2) ? 256 : int'($urandom_range(0, 256));
            repeat (500) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
